cache_fill_fsm: RTL
===================

# cache_fill_fsm

Miss handler that services a cache miss by fetching the full 16-byte block (eight 16-bit words) from the multi-cycle main memory and streaming it into the cache's data and metadata arrays. It sits between the 2-way set-associative cache and the memory model: the cache raises a miss, this block issues the word reads and returns the fill writes, and the cache refills the LRU way. One instance serves the instruction cache and another serves the data cache.

## Interface
- MEM_LATENCY, 4, cycles from `memory_read_en` to the matching `memory_data_valid` (memory is pipelined, one request per cycle)
- WORDS_PER_BLOCK, 8, 16-bit words per cache block
- TIMEOUT_CYCLES, 32, watchdog limit (only with FILL_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- miss_detected  in  1  cache miss this cycle (level; held by the cache until the fill completes)
- miss_address  in  16  byte address of the missing access
- memory_data  in  16  read data from memory
- memory_data_valid  in  1  `memory_data` valid this cycle
- memory_read_en  out  1  issue a memory read this cycle
- memory_address  out  16  byte address of the read being issued
- fill_data  out  16  word to write into the cache data array
- fill_address  out  16  byte address of `fill_data` (selects set and word)
- write_data_array  out  1  one-cycle write strobe for the data array
- write_tag_array  out  1  one-cycle write strobe for the tag/valid/LRU metadata
- fsm_busy  out  1  fill in progress; stalls the pipeline
- fill_error  out  1  sticky watchdog abort flag (tied 0 without FILL_TIMEOUT_EN)

## Operation
- States: IDLE, FILL.
- IDLE: when `miss_detected`=1, capture base = {miss_address[15:4], 4'h0}, clear issue_cnt and recv_cnt, and go to FILL.
- FILL, issue side: while issue_cnt < WORDS_PER_BLOCK, drive `memory_read_en`=1 and `memory_address` = base + 2*issue_cnt, then increment issue_cnt. After the eighth issue, `memory_read_en`=0.
- FILL, return side: on each `memory_data_valid`, drive `write_data_array`=1, `fill_data`=`memory_data` (combinational pass-through) and `fill_address` = base + 2*recv_cnt, then increment recv_cnt.
- On the valid with recv_cnt = WORDS_PER_BLOCK-1, also drive `write_tag_array`=1 in the same cycle. Next state is IDLE.
- `fsm_busy` = (state == FILL).
- Counters are 4 bits wide. Address arithmetic is 16-bit and never carries out of base[15:4].
- `miss_detected` is ignored in FILL. The cache holds it, so a miss still high in the first IDLE cycle after completion starts a new fill. The cache deasserts it once the tag write lands.
- `memory_data_valid` in IDLE, or after recv_cnt has reached WORDS_PER_BLOCK, is ignored and produces no strobes.
- Outputs are 0 whenever no strobe is active. `memory_address`, `fill_address` and `fill_data` are 0 outside FILL.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counters=0, base=0, all outputs 0, `fill_error`=0. Reset during FILL abandons the fill without issuing `write_tag_array`, and in-flight memory responses arriving after reset are ignored.
- Cycle 0: miss seen in IDLE. Cycles 1–8: eight reads issued back-to-back with `fsm_busy`=1.
- First `write_data_array` at cycle 1+MEM_LATENCY (5). Last at cycle 12, together with `write_tag_array`. `fsm_busy`=0 from cycle 13.
- Miss-to-ready penalty is WORDS_PER_BLOCK+MEM_LATENCY+1 = 13 cycles with the defaults.
- Issue and return may overlap in the same cycle; both are handled independently.

## Configuration
- `CACHE_FILL_TIMEOUT_EN` defined:
  - A watchdog counts FILL cycles since the last `memory_data_valid`, or since entry if none has arrived.
  - Reaching TIMEOUT_CYCLES forces IDLE and sets `fill_error`=1 until reset. No `write_tag_array` is issued.
  - The watchdog is cleared on every valid.
- Undefined: no watchdog logic, `fill_error` tied 0, and FILL is exited only on the last word.

## Structure
- Shared cache package holds:
  - the state enum (IDLE, FILL);
  - WORDS_PER_BLOCK, the block-offset width (4) and the word-index width (3), also used by the cache's word-enable decode;
  - the default MEM_LATENCY.
- One natural sub-module: `fill_counter`, a 4-bit counter with clear/enable and a terminal-count output, instantiated twice (issue and receive).

## Test plan
- Basic fill:
  - Stimulus: miss_address=0x1236 with a 4-cycle memory model returning 0xA000+k for word k.
  - Required response: reads to 0x1230,0x1232,…,0x123E in cycles 1–8; fills at cycles 5–12 with fill_data=0xA000..0xA007; write_tag_array only at cycle 12; fsm_busy low at cycle 13.
- Miss held across completion:
  - Stimulus: miss_detected stays 1 through cycle 13, with miss_address changed to 0x4000 at cycle 10.
  - Required response: new fill starts at cycle 13 with base 0x4000.
- Block boundary:
  - Stimulus: miss_address=0xFFFE.
  - Required response: reads 0xFFF0..0xFFFE, with no wrap into 0x0000.
- Spurious valid:
  - Stimulus: memory_data_valid pulsed in IDLE, and a ninth valid after completion.
  - Required response: no write_data_array or write_tag_array strobe.
- Reset mid-fill:
  - Stimulus: rst low at cycle 7, release at cycle 8, responses continue.
  - Required response: all outputs 0 immediately; no write_tag_array; the next miss fills correctly.
- With CACHE_FILL_TIMEOUT_EN:
  - Stimulus: memory never returns valid.
  - Required response: after 32 FILL cycles, fsm_busy=0 and fill_error=1, held until reset.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM states, block geometry and the default memory latency.
// The word-index width is also consumed by the cache's word-enable decode.
package cache_fill_fsm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  localparam int unsigned WORDS_PER_BLOCK     = 8;
  localparam int unsigned BLOCK_OFFSET_W      = 4;
  localparam int unsigned WORD_IDX_W          = 3;
  localparam int unsigned FILL_CNT_W          = 4;
  localparam int unsigned DEFAULT_MEM_LATENCY = 4;

  // Block-aligned base of a byte address.
  function automatic logic [15:0] block_base(input logic [15:0] addr);
    block_base = {addr[15:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
  endfunction

  // Byte address of word idx inside the block at base; idx stays below the
  // block size, so the sum never carries into the tag/set bits.
  function automatic logic [15:0] block_word_addr(input logic [15:0]           base,
                                                  input logic [FILL_CNT_W-1:0] idx);
    block_word_addr = base + {{(16 - FILL_CNT_W - 1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for the fill engine: synchronous clear, enable, and a
// terminal-count flag that also stops further increments.
module cache_fill_fsm_fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned TERMINAL = WORDS_PER_BLOCK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [FILL_CNT_W-1:0] count,
  output logic                  tc
);

  localparam logic [FILL_CNT_W-1:0] TC_VAL = FILL_CNT_W'(TERMINAL);

  logic [FILL_CNT_W-1:0] count_q;
  logic [FILL_CNT_W-1:0] count_d;

  assign count = count_q;
  assign tc    = (count_q == TC_VAL);

  // Next count: clear wins, otherwise advance until terminal.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {FILL_CNT_W{1'b0}};
    end else if (en && !tc) begin
      count_d = count_q + FILL_CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {FILL_CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: reads the eight-word block from pipelined memory and streams
// the returned words into the cache arrays. Optional watchdog: CACHE_FILL_TIMEOUT_EN.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned MEM_LATENCY    = DEFAULT_MEM_LATENCY,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        memory_read_en,
  output logic [15:0] memory_address,
  output logic [15:0] fill_data,
  output logic [15:0] fill_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic        fsm_busy,
  output logic        fill_error
);

  localparam logic [FILL_CNT_W-1:0] LAST_WORD = FILL_CNT_W'(WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  fill_state_e           state_q;
  fill_state_e           state_d;
  logic [15:0]           base_q;
  logic [15:0]           base_d;
  logic                  fill_start_s;
  logic                  wdog_expire_s;
  logic [FILL_CNT_W-1:0] issue_cnt_s;
  logic [FILL_CNT_W-1:0] recv_cnt_s;
  logic                  issue_tc_s;
  logic                  recv_tc_s;

  cache_fill_fsm_fill_counter #(
    .TERMINAL(WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk  (clk),
    .rst_n(rst),
    .clr  (fill_start_s),
    .en   (memory_read_en),
    .count(issue_cnt_s),
    .tc   (issue_tc_s)
  );

  cache_fill_fsm_fill_counter #(
    .TERMINAL(WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk  (clk),
    .rst_n(rst),
    .clr  (fill_start_s),
    .en   (write_data_array),
    .count(recv_cnt_s),
    .tc   (recv_tc_s)
  );

  assign fsm_busy = (state_q == ST_FILL);

  // Next state plus issue/return strobes; issue and return sides run independently.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    fill_start_s     = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = 16'h0000;
    fill_data        = 16'h0000;
    fill_address     = 16'h0000;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          fill_start_s = 1'b1;
          base_d       = block_base(miss_address);
          state_d      = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!issue_tc_s) begin
          memory_read_en = 1'b1;
          memory_address = block_word_addr(base_q, issue_cnt_s);
        end else begin
          memory_read_en = 1'b0;
        end
        // Late or surplus responses (receive count already terminal) are dropped.
        if (memory_data_valid && !recv_tc_s) begin
          write_data_array = 1'b1;
          fill_data        = memory_data;
          fill_address     = block_word_addr(base_q, recv_cnt_s);
          if (recv_cnt_s == LAST_WORD) begin
            write_tag_array = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else if (wdog_expire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured block base.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      base_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam int unsigned       WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_q;
  logic [WD_W-1:0] wdog_d;
  logic            fill_error_q;
  logic            fill_error_d;

  assign wdog_expire_s = (state_q == ST_FILL) && !memory_data_valid && (wdog_q == WD_LAST);
  assign fill_error    = fill_error_q;

  // Watchdog counts FILL cycles since entry or the last response; error is sticky.
  always_comb begin
    wdog_d       = wdog_q;
    fill_error_d = fill_error_q;
    if ((state_q != ST_FILL) || memory_data_valid) begin
      wdog_d = {WD_W{1'b0}};
    end else if (wdog_expire_s) begin
      wdog_d       = {WD_W{1'b0}};
      fill_error_d = 1'b1;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q       <= {WD_W{1'b0}};
      fill_error_q <= 1'b0;
    end else begin
      wdog_q       <= wdog_d;
      fill_error_q <= fill_error_d;
    end
  end
`else
  assign wdog_expire_s = 1'b0;
  assign fill_error    = 1'b0;
`endif

endmodule
